// File: rtl/transmisor_mdio.sv
// transmisor_mdio: MDIO management-frame transmitter with read-data capture.
//
// MDC runs at CLK/2 while MDC_ENABLE is high. Frame bits are launched on
// MDC fall events and read data is captured on MDC rise events.
// A fall event is a CLK edge with MDC_ENABLE=1 and MDC=1.
// A rise event is a CLK edge with MDC_ENABLE=1 and MDC=0.
//
// Read frames (OP = 2'b10):
//   - MDIO is released during the turnaround bits (17 and 16).
//   - The PHY's 16 data bits are sampled on the rise events of bit times
//     15..0.
//
// Optional feature, selected by the macro MDIO_PREAMBLE_EN:
//   - Defined: the frame is preceded by a 32-bit preamble of ones (PRE state).
//   - Undefined (default build): SEND starts directly after start acceptance.
//
// Handshake: MDC_START is a level request.
//   - It is accepted on any enabled CLK edge while the FSM is in IDLE.
//   - BUSY rises on that same edge and stays high until the frame ends.
//   - Requests made while BUSY=1 are ignored.
//   - DATA_RDY is a single-CLK pulse that qualifies a new RD_DATA value.
//
// Debug: fsm_state exposes the FSM state register. IDLE is encoded as 0.
module transmisor_mdio (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MDC_ENABLE,
    input  logic        MDC_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OE,
    output logic        MDIO_OUT,
    output logic        BUSY,
    output logic        DATA_RDY,
    output logic [15:0] RD_DATA,
    output logic [2:0]  fsm_state
);

`ifdef MDIO_PREAMBLE_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        SEND      = 3'd2,
        READ_DATA = 3'd3,
        END       = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd2,
        READ_DATA = 3'd3,
        END       = 3'd4
    } state_t;
`endif

    state_t      state;
    logic [31:0] frame;      // frame latched at start acceptance
    logic [4:0]  cnt;        // bit counter, 0..31, never wraps inside a frame
    logic [15:0] shift;      // read-data shift register
    logic        is_read;

    assign is_read   = (frame[29:28] == 2'b10);
    assign fsm_state = state;

    // Management clock: toggles on every enabled CLK edge, holds otherwise.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            MDC <= 1'b0;
        end else if (MDC_ENABLE) begin
            MDC <= ~MDC;
        end
    end

    // Frame FSM: launches bits on fall events and samples read data on rise events.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            frame    <= 32'h0;
            cnt      <= 5'd0;
            shift    <= 16'h0;
            MDIO_OE  <= 1'b0;
            MDIO_OUT <= 1'b0;
            BUSY     <= 1'b0;
            DATA_RDY <= 1'b0;
            RD_DATA  <= 16'h0;
        end else begin
            DATA_RDY <= 1'b0;
            if (MDC_ENABLE) begin
                case (state)
                    IDLE: begin
                        if (MDC_START) begin
                            frame <= T_DATA;
                            BUSY  <= 1'b1;
                            cnt   <= 5'd0;
`ifdef MDIO_PREAMBLE_EN
                            state <= PRE;
`else
                            state <= SEND;
`endif
                        end
                    end
`ifdef MDIO_PREAMBLE_EN
                    PRE: begin
                        if (MDC) begin
                            MDIO_OE  <= 1'b1;
                            MDIO_OUT <= 1'b1;
                            if (cnt == 5'd31) begin
                                cnt   <= 5'd0;
                                state <= SEND;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
`endif
                    SEND: begin
                        if (MDC) begin
                            if (is_read && cnt == 5'd16) begin
                                // Turnaround is over; the PHY now owns the
                                // data bits. MDIO stays released.
                                state <= READ_DATA;
                            end else begin
                                MDIO_OUT <= frame[5'd31 - cnt];
                                // A read releases the line for TA (cnt 14, 15).
                                MDIO_OE  <= !(is_read && cnt >= 5'd14);
                                if (cnt == 5'd31) begin
                                    state <= END;
                                end else begin
                                    cnt <= cnt + 5'd1;
                                end
                            end
                        end
                    end
                    READ_DATA: begin
                        if (!MDC) begin
                            shift <= {shift[14:0], MDIO_IN};
                            if (cnt == 5'd31) begin
                                RD_DATA  <= {shift[14:0], MDIO_IN};
                                DATA_RDY <= 1'b1;
                                state    <= END;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    END: begin
                        if (MDC) begin
                            MDIO_OE  <= 1'b0;
                            MDIO_OUT <= 1'b0;
                            BUSY     <= 1'b0;
                            cnt      <= 5'd0;
                            state    <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/transmisor_mdio.md
TRANSMISOR_MDIO -- requirements
Module: transmisor_mdio

Interface
REQ-001 SHALL have port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port MDC_ENABLE, input, 1 bit: high lets MDC toggle and the FSM advance; low freezes both.
REQ-004 SHALL have port MDC_START, input, 1 bit: transaction request, sampled in IDLE only.
REQ-005 SHALL have port T_DATA, input, 32 bits: frame ([31:30] ST, [29:28] OP, [27:23] PHY addr, [22:18] REG addr, [17:16] TA, [15:0] data).
REQ-006 SHALL have port MDIO_IN, input, 1 bit: serial read data from the receiver.
REQ-007 SHALL have port MDC, output, 1 bit: management clock, CLK/2.
REQ-008 SHALL have port MDIO_OE, output, 1 bit: high while this block drives MDIO_OUT.
REQ-009 SHALL have port MDIO_OUT, output, 1 bit: serial frame bit.
REQ-010 SHALL have port BUSY, output, 1 bit: high from start acceptance to frame end.
REQ-011 SHALL have port DATA_RDY, output, 1 bit: one-CLK pulse when RD_DATA is updated.
REQ-012 SHALL have port RD_DATA, output, 16 bits: data assembled from a read frame.

Function
REQ-013 SHALL toggle MDC on every CLK edge while MDC_ENABLE=1, giving a bit period of 2 CLK; MDC SHALL hold its value while MDC_ENABLE=0.
REQ-014 SHALL define a fall event as a CLK edge with MDC_ENABLE=1 and MDC=1, and a rise event as a CLK edge with MDC_ENABLE=1 and MDC=0.
REQ-015 SHALL implement states IDLE, PRE (only with MDIO_PREAMBLE_EN), SEND, READ_DATA and END.
REQ-016 In IDLE, on any CLK edge with MDC_START=1 and MDC_ENABLE=1, SHALL latch T_DATA, set BUSY=1 and enter PRE or SEND; MDC_START SHALL be ignored while BUSY=1.
REQ-017 SHALL change MDIO_OUT and MDIO_OE only on fall events; in SEND, SHALL drive T_DATA bits 31 down to 0, one bit per fall event, MSB first.
REQ-018 OP=2'b10 (read): SHALL hold MDIO_OE=1 for bits 31..18, release MDIO_OE=0 on the fall event for bit 17, and go to READ_DATA after bit 16.
REQ-019 In READ_DATA, SHALL shift MDIO_IN into a 16-bit register on each of the next 16 rise events, MSB first.
REQ-020 On the 16th rise event in READ_DATA, SHALL load RD_DATA and pulse DATA_RDY for exactly 1 CLK.
REQ-021 Any OP other than 2'b10 SHALL be sent as a write: MDIO_OE=1 for all 32 bits, no sampling, RD_DATA unchanged, no DATA_RDY.
REQ-022 After the last bit is driven (write) or sampled (read), SHALL enter END; on the next fall event SHALL set MDIO_OE=0, MDIO_OUT=0 and BUSY=0, then return to IDLE.
REQ-023 While idle, MDIO_OE SHALL be 0; no ST/OP/TA field checking SHALL be performed.
REQ-024 A bit counter SHALL count 0..31 and SHALL not wrap within a frame.

Reset
REQ-025 While reset=1: MDC=0, MDIO_OE=0, MDIO_OUT=0, BUSY=0, DATA_RDY=0, RD_DATA=16'h0000, counters cleared, state IDLE.
REQ-026 Reset mid-frame SHALL abort immediately with no completion pulse; the first edge after release SHALL be treated as IDLE.

Configuration
REQ-027 With MDIO_PREAMBLE_EN defined, SHALL send 32 bits of 1 with MDIO_OE=1 (PRE state) before bit 31 of the frame; without it, PRE SHALL not exist and SEND SHALL follow start acceptance directly.

Verification
REQ-028 Write: T_DATA=32'h5A5A_1234 (OP=01), MDC_ENABLE=1 -> 32 rise events with MDIO_OE=1 and sampled MDIO_OUT=5A5A1234 MSB-first; BUSY then falls; DATA_RDY stays 0.
REQ-029 Read: T_DATA=32'h6A5C_0000 (OP=10), receiver model returns 16'hBEEF -> MDIO_OE falls at bit 17; RD_DATA=16'hBEEF; DATA_RDY high for 1 CLK.
REQ-030 MDIO_PREAMBLE_EN defined: any write -> 32 ones before ST; total 64 driven bits.
REQ-031 MDC_ENABLE deasserted for 10 CLK mid-frame -> MDC, MDIO_OUT and bit count frozen; frame completes correctly after re-enable.
REQ-032 reset pulsed at bit 20 of a read -> all outputs at reset values in the same cycle, no DATA_RDY; the next MDC_START runs a full frame.
REQ-033 MDC_START asserted again while BUSY=1 -> ignored; only one frame is observed.
